// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address stack controller.
// State encoding, request opcodes, fault codes and default geometry.
package ras_pkg;

  localparam int ADDR_W_DEF = 19;
  localparam int PTR_W_DEF  = 8;
  localparam logic [18:0] INITIAL_SP_DEF = 19'h1FFFF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4,
    FAULT = 3'd5
  } state_t;

  localparam logic OP_CALL = 1'b0;
  localparam logic OP_RET  = 1'b1;

  localparam logic [1:0] FAULT_NONE = 2'b00;
  localparam logic [1:0] FAULT_OVF  = 2'b01;
  localparam logic [1:0] FAULT_UNF  = 2'b10;

endpackage

// File: rtl/ras_ctrl.sv
// Return-address stack controller: sequences an external 1-port stack RAM
// (1-cycle read) for call/ret requests and tracks sp, depth and sticky faults.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int PTR_W  = PTR_W_DEF,
  parameter int DEPTH  = 256,
  parameter logic [ADDR_W-1:0] INITIAL_SP = ADDR_W'(INITIAL_SP_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [PTR_W-1:0]  mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] sp,
  output logic [PTR_W:0]    depth,
  output logic              empty,
  output logic              full,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              clr_fault
);

  state_t             state_reg, state_next;
  logic [ADDR_W-1:0]  sp_reg, sp_next;
  logic [PTR_W:0]     depth_reg, depth_next;
  logic               fault_reg, fault_next;
  logic [1:0]         fault_code_reg, fault_code_next;
  logic [ADDR_W-1:0]  rsp_addr_reg, rsp_addr_next;
  logic               rsp_err_reg, rsp_err_next;
  logic [ADDR_W-1:0]  addr_latch_reg, addr_latch_next;

  logic [ADDR_W-1:0]  sp_dec;
  logic               full_int, empty_int;

  assign sp_dec    = sp_reg - ADDR_W'(1);
  assign full_int  = (depth_reg == (PTR_W+1)'(DEPTH));
  assign empty_int = (depth_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      sp_reg         <= INITIAL_SP;
      depth_reg      <= '0;
      fault_reg      <= 1'b0;
      fault_code_reg <= FAULT_NONE;
      rsp_addr_reg   <= '0;
      rsp_err_reg    <= 1'b0;
      addr_latch_reg <= '0;
    end else begin
      state_reg      <= state_next;
      sp_reg         <= sp_next;
      depth_reg      <= depth_next;
      fault_reg      <= fault_next;
      fault_code_reg <= fault_code_next;
      rsp_addr_reg   <= rsp_addr_next;
      rsp_err_reg    <= rsp_err_next;
      addr_latch_reg <= addr_latch_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    sp_next         = sp_reg;
    depth_next      = depth_reg;
    fault_next      = fault_reg;
    fault_code_next = fault_code_reg;
    rsp_addr_next   = rsp_addr_reg;
    rsp_err_next    = rsp_err_reg;
    addr_latch_next = addr_latch_reg;
    req_ready       = 1'b0;
    rsp_valid       = 1'b0;
    mem_en          = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = sp_reg[PTR_W-1:0];
    mem_wdata       = addr_latch_reg;

    // A clear acts everywhere; a fault raised in the same cycle overrides it below.
    if (clr_fault) begin
      fault_next      = 1'b0;
      fault_code_next = FAULT_NONE;
    end

    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_op == OP_CALL) begin
            if (full_int) begin
              state_next      = RESP;
              rsp_err_next    = 1'b1;
              rsp_addr_next   = req_addr;
              fault_next      = 1'b1;
              fault_code_next = FAULT_OVF;
            end else begin
              addr_latch_next = req_addr;
              state_next      = WRITE;
            end
          end else begin
            if (empty_int) begin
              state_next      = RESP;
              rsp_err_next    = 1'b1;
              rsp_addr_next   = '0;
              fault_next      = 1'b1;
              fault_code_next = FAULT_UNF;
            end else begin
              state_next = READ;
            end
          end
        end
      end
      WRITE: begin
        mem_en        = 1'b1;
        mem_we        = 1'b1;
        mem_addr      = sp_dec[PTR_W-1:0];
        sp_next       = sp_dec;
        depth_next    = depth_reg + (PTR_W+1)'(1);
        rsp_addr_next = addr_latch_reg;
        rsp_err_next  = 1'b0;
        state_next    = RESP;
      end
      READ: begin
        mem_en     = 1'b1;
        sp_next    = sp_reg + ADDR_W'(1);
        depth_next = depth_reg - (PTR_W+1)'(1);
        state_next = WAIT;
      end
      WAIT: begin
        rsp_addr_next = mem_rdata;
        rsp_err_next  = 1'b0;
        state_next    = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        // A clear arriving with the handshake spares the trip through FAULT.
        if (rsp_ready) begin
          state_next = (fault_reg && !clr_fault) ? FAULT : IDLE;
        end
      end
      FAULT: begin
        if (clr_fault) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign rsp_addr   = rsp_addr_reg;
  assign rsp_err    = rsp_err_reg;
  assign sp         = sp_reg;
  assign depth      = depth_reg;
  assign empty      = empty_int;
  assign full       = full_int;
  assign fault      = fault_reg;
  assign fault_code = fault_code_reg;

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed self-checking bench for ras_ctrl with a behavioural 1-port,
// 1-cycle-read stack RAM attached.
module tb_ras_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [18:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [18:0] rsp_addr;
  logic        rsp_err;
  logic        rsp_ready = 1'b1;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [18:0] mem_wdata;
  logic [18:0] mem_rdata = '0;
  logic [18:0] sp;
  logic [8:0]  depth;
  logic        empty;
  logic        full;
  logic        fault;
  logic [1:0]  fault_code;
  logic        clr_fault = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [18:0] ram [0:255];
  int          mem_strobes = 0;
  logic [7:0]  last_widx = '0;
  logic [18:0] last_wdata = '0;

  ras_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr), .rsp_err(rsp_err), .rsp_ready(rsp_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .sp(sp), .depth(depth), .empty(empty), .full(full),
    .fault(fault), .fault_code(fault_code), .clr_fault(clr_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      mem_strobes = mem_strobes + 1;
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        last_widx  = mem_addr;
        last_wdata = mem_wdata;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    clr_fault = 1'b0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_fault = 1'b1;
    @(posedge clk);
    #1;
    clr_fault = 1'b0;
  endtask

  // Issues one request from IDLE; lat counts edges from the accept edge to rsp_valid.
  task automatic do_req(input logic op, input logic [18:0] addr, input bit consume,
                        output logic [18:0] ra, output logic re, output int lat);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    ra = rsp_addr;
    re = rsp_err;
    $display("txn op=%s addr=%05h -> rsp_addr=%05h err=%0b lat=%0d sp=%05h depth=%0d",
             op ? "ret " : "call", addr, ra, re, lat, sp, depth);
    if (consume) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (sp !== 19'h1FFFF) begin failures++; $display("FAIL reset_sp actual=%h expected=1ffff", sp); end
    checks++; if (depth !== 9'd0) begin failures++; $display("FAIL reset_depth actual=%0d expected=0", depth); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags actual=e%b f%b expected=e1 f0", empty, full); end
    checks++; if (fault !== 1'b0 || fault_code !== 2'b00) begin failures++; $display("FAIL reset_fault actual=%b/%b expected=0/00", fault, fault_code); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_addr !== 19'h0) begin failures++; $display("FAIL reset_rsp actual=v%b e%b a%h expected=v0 e0 a0", rsp_valid, rsp_err, rsp_addr); end
    checks++; if (req_ready !== 1'b1 || mem_en !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL reset_ctrl actual=rdy%b en%b we%b expected=rdy1 en0 we0", req_ready, mem_en, mem_we); end
  endtask

  task automatic test_single_call();
    logic [18:0] ra; logic re; int lat;
    apply_reset();
    do_req(1'b0, 19'h00100, 1'b0, ra, re, lat);
    checks++; if (lat !== 2) begin failures++; $display("FAIL call_latency actual=%0d expected=2", lat); end
    checks++; if (ra !== 19'h00100 || re !== 1'b0) begin failures++; $display("FAIL call_rsp actual=%h/%b expected=00100/0", ra, re); end
    checks++; if (last_widx !== 8'hFE || last_wdata !== 19'h00100) begin failures++; $display("FAIL call_write actual=idx%h d%h expected=idxfe d00100", last_widx, last_wdata); end
    checks++; if (sp !== 19'h1FFFE || depth !== 9'd1) begin failures++; $display("FAIL call_sp_depth actual=%h/%0d expected=1fffe/1", sp, depth); end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL call_return_idle actual=rdy%b v%b expected=rdy1 v0", req_ready, rsp_valid); end
  endtask

  task automatic test_lifo();
    logic [18:0] ra; logic re; int lat;
    logic [18:0] pushes [3];
    pushes[0] = 19'h00100; pushes[1] = 19'h00200; pushes[2] = 19'h00300;
    apply_reset();
    for (int i = 0; i < 3; i++) do_req(1'b0, pushes[i], 1'b1, ra, re, lat);
    checks++; if (sp !== 19'h1FFFC || depth !== 9'd3) begin failures++; $display("FAIL lifo_after_push actual=%h/%0d expected=1fffc/3", sp, depth); end
    for (int i = 2; i >= 0; i--) begin
      do_req(1'b1, 19'h0, 1'b1, ra, re, lat);
      checks++; if (ra !== pushes[i] || re !== 1'b0) begin failures++; $display("FAIL lifo_pop%0d actual=%h/%b expected=%h/0", i, ra, re, pushes[i]); end
      checks++; if (lat !== 3) begin failures++; $display("FAIL lifo_ret_latency actual=%0d expected=3", lat); end
    end
    checks++; if (sp !== 19'h1FFFF || depth !== 9'd0 || empty !== 1'b1) begin failures++; $display("FAIL lifo_final actual=%h/%0d/e%b expected=1ffff/0/e1", sp, depth, empty); end
  endtask

  task automatic test_underflow();
    logic [18:0] ra; logic re; int lat; int strobes0;
    apply_reset();
    strobes0 = mem_strobes;
    do_req(1'b1, 19'h0, 1'b1, ra, re, lat);
    checks++; if (lat !== 1 || re !== 1'b1 || ra !== 19'h0) begin failures++; $display("FAIL unf_rsp actual=lat%0d e%b a%h expected=lat1 e1 a0", lat, re, ra); end
    checks++; if (fault !== 1'b1 || fault_code !== 2'b10) begin failures++; $display("FAIL unf_fault actual=%b/%b expected=1/10", fault, fault_code); end
    checks++; if (mem_strobes !== strobes0) begin failures++; $display("FAIL unf_no_mem actual=%0d expected=%0d", mem_strobes, strobes0); end
    repeat (3) begin
      checks++; if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL unf_fault_hold actual=rdy%b v%b expected=rdy0 v0", req_ready, rsp_valid); end
      @(posedge clk); #1;
    end
    pulse_clr();
    checks++; if (req_ready !== 1'b1 || fault !== 1'b0 || fault_code !== 2'b00) begin failures++; $display("FAIL unf_clear actual=rdy%b f%b c%b expected=rdy1 f0 c00", req_ready, fault, fault_code); end
  endtask

  task automatic test_overflow();
    logic [18:0] ra; logic re; int lat; int strobes0;
    apply_reset();
    for (int i = 0; i < 256; i++) do_req(1'b0, 19'(i), 1'b1, ra, re, lat);
    checks++; if (full !== 1'b1 || depth !== 9'd256 || sp !== 19'h1FEFF) begin failures++; $display("FAIL ovf_full actual=f%b d%0d sp%h expected=f1 d256 sp1feff", full, depth, sp); end
    strobes0 = mem_strobes;
    do_req(1'b0, 19'h0ABCD, 1'b1, ra, re, lat);
    checks++; if (lat !== 1 || re !== 1'b1 || ra !== 19'h0ABCD) begin failures++; $display("FAIL ovf_rsp actual=lat%0d e%b a%h expected=lat1 e1 a0abcd", lat, re, ra); end
    checks++; if (fault !== 1'b1 || fault_code !== 2'b01) begin failures++; $display("FAIL ovf_fault actual=%b/%b expected=1/01", fault, fault_code); end
    checks++; if (mem_strobes !== strobes0 || sp !== 19'h1FEFF || depth !== 9'd256) begin failures++; $display("FAIL ovf_no_change actual=s%0d sp%h d%0d expected=s%0d sp1feff d256", mem_strobes, sp, depth, strobes0); end
    pulse_clr();
    do_req(1'b1, 19'h0, 1'b1, ra, re, lat);
    checks++; if (ra !== 19'h000FF || re !== 1'b0) begin failures++; $display("FAIL ovf_top_pop actual=%h/%b expected=000ff/0", ra, re); end
  endtask

  task automatic test_hold();
    logic [18:0] ra; logic re; int lat; int strobes0;
    apply_reset();
    do_req(1'b0, 19'h12345, 1'b1, ra, re, lat);
    rsp_ready = 1'b0;
    do_req(1'b1, 19'h0, 1'b0, ra, re, lat);
    checks++; if (lat !== 3 || ra !== 19'h12345) begin failures++; $display("FAIL hold_first actual=lat%0d a%h expected=lat3 a12345", lat, ra); end
    strobes0 = mem_strobes;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_addr !== 19'h12345 || rsp_err !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("FAIL hold_stable%0d actual=v%b a%h e%b rdy%b expected=v1 a12345 e0 rdy0", c, rsp_valid, rsp_addr, rsp_err, req_ready); end
    end
    checks++; if (mem_strobes !== strobes0) begin failures++; $display("FAIL hold_no_mem actual=%0d expected=%0d", mem_strobes, strobes0); end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL hold_release actual=v%b rdy%b expected=v0 rdy1", rsp_valid, req_ready); end
  endtask

  task automatic test_rst_mid();
    logic [18:0] ra; logic re; int lat;
    apply_reset();
    do_req(1'b0, 19'h0AAAA, 1'b1, ra, re, lat);
    req_valid = 1'b1; req_op = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (sp !== 19'h1FFFF || depth !== 9'd0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL rstmid_state actual=sp%h d%0d v%b rdy%b expected=sp1ffff d0 v0 rdy1", sp, depth, rsp_valid, req_ready); end
    do_req(1'b1, 19'h0, 1'b1, ra, re, lat);
    checks++; if (re !== 1'b1 || lat !== 1 || fault_code !== 2'b10) begin failures++; $display("FAIL rstmid_ret actual=e%b lat%0d c%b expected=e1 lat1 c10", re, lat, fault_code); end
    pulse_clr();
  endtask

  initial begin
    test_reset();
    test_single_call();
    test_lifo();
    test_underflow();
    test_overflow();
    test_hold();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
